mem_access_ctrl: RTL and testbench

- Initiator side of the data-RAM port: sits between the pipeline MEM stage and `data_ram`.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the RAM enable, write enable, byte-lane select, word address and lane-steered write data.
- Extracts and sign/zero-extends load data and returns it over a valid/ready response channel.

---
 rtl/mem_access_ctrl_pkg.sv | 35 +++
 rtl/mem_access_ctrl_lane_align.sv | 54 +++++
 rtl/mem_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// mem_access_ctrl_pkg : shared encodings for the data-RAM access controller.
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;
   localparam logic [1:0] SIZE_RSVD = 2'd3;

   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic        CHIP_ENABLE  = 1'b1;
   localparam logic        WRITE_ENABLE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = a[0];
         SIZE_WORD: is_misaligned = (a != 2'b00);
         default:   is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_lane_align.sv
// ============================================================================
// mem_lane_align : byte-lane select, store-data steering, load extraction.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [1:0]        size_i,
   input  logic [1:0]        addr_lo_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [3:0]        write_sel_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] w_shifted;

   assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};

   // Reserved size falls through to word handling.
   always_comb begin
      write_sel_o = 4'b1111;
      wdata_o     = wdata_i;
      rdata_o     = w_shifted;
      case (size_i)
         SIZE_BYTE: begin
            write_sel_o = 4'b0001 << addr_lo_i;
            wdata_o     = {(DATA_W/8){wdata_i[7:0]}};
            rdata_o     = signed_i ? {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]}
                                   : {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
         end
         SIZE_HALF: begin
            write_sel_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o     = {(DATA_W/16){wdata_i[15:0]}};
            rdata_o     = signed_i ? {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]}
                                   : {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
         end
         default: begin
            write_sel_o = 4'b1111;
            wdata_o     = wdata_i;
            rdata_o     = w_shifted;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : single-outstanding load/store initiator for data_ram.
// Option macro MEM_ALIGN_CHECK_EN: flag and suppress misaligned accesses.
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_signed_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic              ram_en_o,
   output logic              ram_write_en_o,
   output logic [3:0]        ram_write_sel_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_write_data_o,
   input  logic [DATA_W-1:0] ram_read_data_i
);

   state_e            state_q, state_d;
   logic              write_q, signed_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [1:0]        w_size_eff;
   logic [ADDR_W-1:0] w_addr_eff;
   logic              w_access_ok;
   logic              w_bad;
   logic [3:0]        w_sel;
   logic [DATA_W-1:0] w_wdata_steer;
   logic [DATA_W-1:0] w_load_data;

`ifdef MEM_ALIGN_CHECK_EN
   assign w_bad      = is_misaligned(size_q, addr_q[1:0]);
   assign w_size_eff = size_q;
   assign w_addr_eff = addr_q;
`else
   assign w_bad      = 1'b0;
   assign w_size_eff = (size_q == SIZE_RSVD) ? SIZE_WORD : size_q;
   always_comb begin
      w_addr_eff = addr_q;
      if (w_size_eff == SIZE_HALF)
         w_addr_eff[0] = 1'b0;
      else if (w_size_eff == SIZE_WORD)
         w_addr_eff[1:0] = 2'b00;
   end
`endif

   // Reset on the edge leaving ACCESS must not let the RAM commit a write.
   assign w_access_ok = !w_bad && !rst;

   mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
      .size_i      (w_size_eff),
      .addr_lo_i   (w_addr_eff[1:0]),
      .signed_i    (signed_q),
      .wdata_i     (wdata_q),
      .rdata_i     (ram_read_data_i),
      .write_sel_o (w_sel),
      .wdata_o     (w_wdata_steer),
      .rdata_o     (w_load_data)
   );

   always_comb begin
      state_d          = state_q;
      rdata_d          = rdata_q;
      err_d            = err_q;
      req_ready_o      = 1'b0;
      resp_valid_o     = 1'b0;
      ram_en_o         = 1'b0;
      ram_write_en_o   = 1'b0;
      ram_write_sel_o  = 4'b0000;
      ram_addr_o       = '0;
      ram_write_data_o = '0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i)
               state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            if (w_access_ok) begin
               ram_en_o         = CHIP_ENABLE;
               ram_write_en_o   = write_q ? WRITE_ENABLE : ~WRITE_ENABLE;
               ram_write_sel_o  = w_sel;
               ram_addr_o       = w_addr_eff;
               ram_write_data_o = w_wdata_steer;
            end
            rdata_d = (write_q || w_bad) ? ZERO_WORD : w_load_data;
            err_d   = w_bad;
         end
         ST_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         size_q   <= SIZE_BYTE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (state_q == ST_IDLE && req_valid_i) begin
            write_q  <= req_write_i;
            signed_q <= req_signed_i;
            size_q   <= req_size_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
         end
      end
   end

   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : directed vector bench with a behavioural data RAM.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        ram_en, ram_write_en;
   logic [3:0]  ram_write_sel;
   logic [31:0] ram_addr, ram_write_data, ram_read_data;

   logic [31:0] mem [0:63];
   int n_pass  = 0;
   int n_total = 0;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_write_i      (req_write),
      .req_size_i       (req_size),
      .req_signed_i     (req_signed),
      .req_addr_i       (req_addr),
      .req_wdata_i      (req_wdata),
      .resp_valid_o     (resp_valid),
      .resp_ready_i     (resp_ready),
      .resp_rdata_o     (resp_rdata),
      .resp_err_o       (resp_err),
      .ram_en_o         (ram_en),
      .ram_write_en_o   (ram_write_en),
      .ram_write_sel_o  (ram_write_sel),
      .ram_addr_o       (ram_addr),
      .ram_write_data_o (ram_write_data),
      .ram_read_data_i  (ram_read_data)
   );

   assign ram_read_data = ram_en ? mem[ram_addr[7:2]] : 32'h0;

   always @(posedge clk) begin
      if (ram_en && ram_write_en) begin
         for (int k = 0; k < 4; k++)
            if (ram_write_sel[k])
               mem[ram_addr[7:2]][8*k +: 8] <= ram_write_data[8*k +: 8];
      end
   end

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        en;
      logic [3:0]  sel;
      logic [31:0] raddr;
      logic [31:0] wd;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic en, input logic [3:0] sel, input logic [31:0] raddr,
                      input logic [31:0] wd, input logic [31:0] rdata, input logic err);
      vecs.push_back('{wr, sz, sg, addr, wdata, en, sel, raddr, wd, rdata, err});
   endtask

   // Entered #1 after a rising edge with the DUT idle; returns likewise.
   task automatic txn(input vec_t v, input int idx);
      int n;
      string tag;
      tag = $sformatf("v%0d", idx);
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
      req_write = v.wr; req_size = v.sz; req_signed = v.sg;
      req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, "_ram_en"}, {31'b0, ram_en}, {31'b0, v.en});
      if (v.en) begin
         chk({tag, "_we"}, {31'b0, ram_write_en}, {31'b0, v.wr});
         chk({tag, "_sel"}, {28'b0, ram_write_sel}, {28'b0, v.sel});
         chk({tag, "_addr"}, ram_addr, v.raddr);
         if (v.wr) chk({tag, "_wdata"}, ram_write_data, v.wd);
      end
      @(posedge clk); #1;
      chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
      chk({tag, "_rdata"}, resp_rdata, v.rdata);
      chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, v.err});
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, "_resp_err"}, {31'b0, resp_err}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_ram_en"}, {31'b0, ram_en}, 32'd0);
      chk({tag, "_ram_we"}, {31'b0, ram_write_en}, 32'd0);
      chk({tag, "_ram_sel"}, {28'b0, ram_write_sel}, 32'd0);
      chk({tag, "_ram_addr"}, ram_addr, 32'd0);
      chk({tag, "_ram_wdata"}, ram_write_data, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] held;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;

      //  wr sz  sg addr    wdata        en    sel      raddr   wd           rdata        err
      add(1, 2, 0, 32'h10, 32'h12345678, 1, 4'b1111, 32'h10, 32'h12345678, 32'h0,        0);
      add(0, 2, 0, 32'h10, 32'h0,        1, 4'b1111, 32'h10, 32'h0,        32'h12345678, 0);
      add(1, 0, 0, 32'h13, 32'h000000AB, 1, 4'b1000, 32'h13, 32'hABABABAB, 32'h0,        0);
      add(0, 0, 1, 32'h13, 32'h0,        1, 4'b1000, 32'h13, 32'h0,        32'hFFFFFFAB, 0);
      add(0, 0, 0, 32'h13, 32'h0,        1, 4'b1000, 32'h13, 32'h0,        32'h000000AB, 0);
      add(1, 1, 0, 32'h22, 32'h00008001, 1, 4'b1100, 32'h22, 32'h80018001, 32'h0,        0);
      add(0, 1, 1, 32'h22, 32'h0,        1, 4'b1100, 32'h22, 32'h0,        32'hFFFF8001, 0);
      add(0, 1, 0, 32'h22, 32'h0,        1, 4'b1100, 32'h22, 32'h0,        32'h00008001, 0);
      add(0, 0, 1, 32'h11, 32'h0,        1, 4'b0010, 32'h11, 32'h0,        32'h00000056, 0);
      add(0, 0, 1, 32'h10, 32'h0,        1, 4'b0001, 32'h10, 32'h0,        32'h00000078, 0);
      add(0, 1, 1, 32'h12, 32'h0,        1, 4'b1100, 32'h12, 32'h0,        32'hFFFFAB34, 0);
      add(0, 1, 1, 32'h10, 32'h0,        1, 4'b0011, 32'h10, 32'h0,        32'h00005678, 0);
      add(0, 2, 0, 32'h11, 32'h0,        !CHK, 4'b1111, 32'h10, 32'h0,
          CHK ? 32'h0 : 32'hAB345678, CHK);
      add(0, 3, 0, 32'h10, 32'h0,        !CHK, 4'b1111, 32'h10, 32'h0,
          CHK ? 32'h0 : 32'hAB345678, CHK);
      add(1, 0, 0, 32'h21, 32'h0000005A, 1, 4'b0010, 32'h21, 32'h5A5A5A5A, 32'h0,        0);
      add(0, 2, 0, 32'h20, 32'h0,        1, 4'b1111, 32'h20, 32'h0,        32'h80015A00, 0);
      add(1, 1, 0, 32'h23, 32'h0000BEEF, !CHK, 4'b1100, 32'h22, 32'hBEEFBEEF, 32'h0,     CHK);
      add(0, 2, 0, 32'h20, 32'h0,        1, 4'b1111, 32'h20, 32'h0,
          CHK ? 32'h80015A00 : 32'hBEEF5A00, 0);

      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("in_reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_all_zero("post_reset");

      foreach (vecs[i]) txn(vecs[i], i);

      // Backpressure: response held while a second request waits.
      req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_size = 2'd0; req_addr = 32'h13;
      @(posedge clk); #1;
      held = resp_rdata;
      chk("bp_first_rdata", held, 32'hAB345678);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_valid_c%0d", c), {31'b0, resp_valid}, 32'd1);
         chk($sformatf("bp_ready_c%0d", c), {31'b0, req_ready}, 32'd0);
         chk($sformatf("bp_rdata_c%0d", c), resp_rdata, 32'hAB345678);
         chk($sformatf("bp_ram_en_c%0d", c), {31'b0, ram_en}, 32'd0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
      chk("bp_idle_valid", {31'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp_second_en", {31'b0, ram_en}, 32'd1);
      chk("bp_second_addr", ram_addr, 32'h13);
      @(posedge clk); #1;
      chk("bp_second_rdata", resp_rdata, 32'h000000AB);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;

      // Reset during the ACCESS cycle of a store.
      req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_access_en_before", {31'b0, ram_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_access_en_gated", {31'b0, ram_en}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk_all_zero("rst_access");
      txn('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h10, 32'h0, 32'hAB345678, 1'b0},
          99);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
